cvp14_synth: RTL and testbench
==============================

// Module: cvp14_synth
// PURPOSE
//  Multi-cycle 16-bit scalar core for the CVP14 platform. It fetches, decodes and executes one instruction at a time.
//  It talks to a single-port word-addressed DRAM over Addr/RD/WR/DataOut/DataIn.
//  The DRAM samples Addr/RD/WR/DataOut at a rising Clk1. Read data is valid on DataIn throughout the next cycle.
//  V exports the sticky-per-ADD overflow flag.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
// PORTS
//  Clk1     in   1   single system clock, rising-edge
//  Reset    in   1   synchronous, active-high reset
//  DataIn   in   16  read data from DRAM (valid the cycle after RD)
//  Addr     out  16  DRAM word address
//  RD       out  1   DRAM read strobe
//  WR       out  1   DRAM write strobe
//  DataOut  out  16  DRAM write data
//  V        out  1   overflow flag (V_flag)
// BEHAVIOUR
//  - One clock (Clk1). Reset is synchronous and active-high. Clk2 does not exist.
//  - Regs: r0..r7 x16, r0 reads 0 and ignores writes. Also PC[15:0], IR[15:0], V_flag, state.
//  - Encoding: op[15:12] rd[11:9] rs[8:6] rt[5:3] imm8[7:0] off6[5:0] off12[11:0]. Offsets are signed.
//  - 0:ADD rd=rs+rt (wraps), V_flag=signed ovf. 1:AND. 2:LLB rd=sext(imm8). 3:LHB rd[15:8]=imm8, low byte kept.
//  - 4:LD rd=M[rs+sext(off6)]. 5:ST M[rs+sext(off6)]=rd.
//  - 6:J PC=PCi+1+off12. 7:BOV, same target if V_flag=1, else PC=PCi+1. PCi is the instruction address.
//  - F:HALT. 8-E are NOP. Only ADD writes V_flag (set or clear).
//  - States: RST -> FETCH -> DECODE -> EXEC -> (MEMRD for LD) -> FETCH. HALT is terminal.
//  - RST: entered while Reset=1. PC=RESET_PC, regs=0, V_flag=0. Outputs Addr=0, RD=0, WR=0, DataOut=0, V=0.
//    RST always exits to FETCH on the next edge with Reset=0.
//  - FETCH: Addr=PC, RD=1.
//  - DECODE: IR<=DataIn, PC<=PC+1.
//  - EXEC: ALU op / branch / LLB / LHB complete here.
//    LD drives Addr=ea, RD=1 and goes to MEMRD. MEMRD does rd<=DataIn.
//    ST drives Addr=ea, WR=1, DataOut=rd for exactly one cycle.
//  - Latency: ALU/branch/ST/NOP = 3 cycles. LD = 4 cycles.
//  - Outside access cycles: Addr=PC, RD=0, WR=0, DataOut=0. RD and WR are never asserted together.
//  - ea and PC arithmetic are modulo 2^16 (FFFF+1 wraps to 0000).
//  - HALT: RD=WR=0, PC and regs frozen until Reset.
//  - Reset asserted in any state, including mid-LD/ST: next state RST. A pending write is dropped if not yet issued.
// CONFIGURATION
//  CVP14_SAT_ADD_EN defined:
//    ADD saturates on overflow: positive -> 16'h7FFF, negative -> 16'h8000. V_flag is still set.
//  CVP14_SAT_ADD_EN undefined:
//    ADD wraps, V_flag is set.
// TESTING
//  - Reset: hold 1 cycle -> RD=WR=V=0, Addr=0. Next cycle FETCH: Addr=0000, RD=1. Instr at 0 reaches EXEC on cycle 3.
//  - M[0..2]={227F,327F,0448}: r1=7F7F. r2=FEFE, V=1.
//    With CVP14_SAT_ADD_EN: r2=7FFF, V=1.
//  - M[3]=5405 (ST r2,[r0+5]) -> one cycle with WR=1, Addr=0005, DataOut=FEFE. RD=0 that cycle.
//  - M[4]=4605 (LD r3,[r0+5]), M[5]=5606 (ST r3) -> RD at Addr=0005, then WR at Addr=0006 with DataOut=FEFE.
//  - M[6]=7002 (BOV +2, V=1) -> next fetch Addr=0009. With V=0 -> next fetch Addr=0007.
//    M[9]=F000 -> RD stays 0, PC frozen at 000A.
//  - Reset pulsed during LD's MEMRD -> r3 unchanged (0), V=0, refetch from 0000.

Source files
------------

// File: rtl/cvp14_synth.sv
// cvp14_synth: multi-cycle 16-bit scalar core (fetch/decode/execute, one instruction at a time).
// Latency: ALU/branch/ST/NOP = 3 cycles, LD = 4 cycles; HALT is terminal until Reset.
// Backpressure: none - DRAM is fixed-timing (read data valid the cycle after RD).
//
// Ports:
//   Clk1    in   1  system clock, rising edge
//   Reset   in   1  synchronous active-high reset
//   DataIn  in  16  DRAM read data (valid the cycle after RD)
//   Addr    out 16  DRAM word address
//   RD      out  1  DRAM read strobe
//   WR      out  1  DRAM write strobe
//   DataOut out 16  DRAM write data
//   V       out  1  overflow flag, written only by ADD
//
// Build option: CVP14_SAT_ADD_EN - when defined, ADD saturates on signed
// overflow (0x7FFF / 0x8000) instead of wrapping; V is set either way.
//
// All bus outputs are registered: each state computes the outputs of the
// state it hands over to, so the DRAM sees clean signals at every edge.

module cvp14_synth #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] DataIn,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    output logic        V
);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_LLB  = 4'h2;
    localparam logic [3:0] OP_LHB  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_J    = 4'h6;
    localparam logic [3:0] OP_BOV  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [8];
    logic        r_v;
    logic [15:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [15:0] r_dout;

    // Decode-time view: the instruction is still on DataIn, so the LD/ST
    // address and store data are formed from it directly.
    logic [3:0]  w_dec_op;
    logic [15:0] w_dec_ea;
    logic [15:0] w_dec_st_dat;

    assign w_dec_op     = DataIn[15:12];
    assign w_dec_ea     = r_regs[DataIn[8:6]] + {{10{DataIn[5]}}, DataIn[5:0]};
    assign w_dec_st_dat = r_regs[DataIn[11:9]];

    // Execute-time view, from the latched instruction.
    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [15:0] w_rs_val;
    logic [15:0] w_rt_val;
    logic [15:0] w_rd_val;
    logic [15:0] w_sum;
    logic        w_ovf;
    logic [15:0] w_add_res;
    logic [15:0] w_br_tgt;
    logic        w_taken;
    logic [15:0] w_pc_next;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:9];
    assign w_rs_val = r_regs[r_ir[8:6]];
    assign w_rt_val = r_regs[r_ir[5:3]];
    assign w_rd_val = r_regs[w_rd];
    assign w_sum    = w_rs_val + w_rt_val;
    // Signed overflow: operands agree in sign, result does not.
    assign w_ovf    = (w_rs_val[15] == w_rt_val[15]) && (w_sum[15] != w_rs_val[15]);

`ifdef CVP14_SAT_ADD_EN
    assign w_add_res = !w_ovf ? w_sum : (w_rs_val[15] ? 16'h8000 : 16'h7FFF);
`else
    assign w_add_res = w_sum;
`endif

    // r_pc already holds PCi+1 in EXEC, so the target is PCi+1+off12.
    assign w_br_tgt  = r_pc + {{4{r_ir[11]}}, r_ir[11:0]};
    assign w_taken   = (w_op == OP_J) || ((w_op == OP_BOV) && r_v);
    assign w_pc_next = w_taken ? w_br_tgt : r_pc;

    // Register-file write port: ALU results in EXEC, load data in MEMRD.
    logic        w_wb_en;
    logic [15:0] w_wb_val;

    always_comb begin
        w_wb_en  = 1'b0;
        w_wb_val = 16'h0000;
        if (r_state == S_EXEC) begin
            case (w_op)
                OP_ADD: begin w_wb_en = 1'b1; w_wb_val = w_add_res; end
                OP_AND: begin w_wb_en = 1'b1; w_wb_val = w_rs_val & w_rt_val; end
                OP_LLB: begin w_wb_en = 1'b1; w_wb_val = {{8{r_ir[7]}}, r_ir[7:0]}; end
                OP_LHB: begin w_wb_en = 1'b1; w_wb_val = {r_ir[7:0], w_rd_val[7:0]}; end
                default: ;
            endcase
        end else if (r_state == S_MEMRD) begin
            w_wb_en  = 1'b1;
            w_wb_val = DataIn;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            r_state <= S_RST;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
            r_v     <= 1'b0;
            r_addr  <= 16'h0000;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_dout  <= 16'h0000;
            for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
        end else begin
            // r0 is hard-wired to zero by never writing it.
            if (w_wb_en && (w_rd != 3'd0)) r_regs[w_rd] <= w_wb_val;

            case (r_state)
                S_RST: begin
                    r_state <= S_FETCH;
                    r_addr  <= r_pc;
                    r_rd    <= 1'b1;
                end
                S_FETCH: begin
                    r_state <= S_DECODE;
                    r_addr  <= r_pc;
                    r_rd    <= 1'b0;
                end
                S_DECODE: begin
                    r_ir    <= DataIn;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= S_EXEC;
                    if (w_dec_op == OP_LD) begin
                        r_addr <= w_dec_ea;
                        r_rd   <= 1'b1;
                    end else if (w_dec_op == OP_ST) begin
                        r_addr <= w_dec_ea;
                        r_wr   <= 1'b1;
                        r_dout <= w_dec_st_dat;
                    end else begin
                        r_addr <= r_pc + 16'd1;
                    end
                end
                S_EXEC: begin
                    r_wr   <= 1'b0;
                    r_dout <= 16'h0000;
                    if (w_op == OP_ADD) r_v <= w_ovf;
                    if (w_op == OP_LD) begin
                        r_state <= S_MEMRD;
                        r_addr  <= r_pc;
                        r_rd    <= 1'b0;
                    end else if (w_op == OP_HALT) begin
                        r_state <= S_HALT;
                        r_addr  <= r_pc;
                        r_rd    <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_pc_next;
                        r_addr  <= w_pc_next;
                        r_rd    <= 1'b1;
                    end
                end
                S_MEMRD: begin
                    r_state <= S_FETCH;
                    r_addr  <= r_pc;
                    r_rd    <= 1'b1;
                end
                S_HALT: begin
                    r_rd <= 1'b0;
                    r_wr <= 1'b0;
                end
                default: r_state <= S_RST;
            endcase
        end
    end

    assign Addr    = r_addr;
    assign RD      = r_rd;
    assign WR      = r_wr;
    assign DataOut = r_dout;
    assign V       = r_v;

endmodule

// File: tb/tb_cvp14_synth.sv
// tb_cvp14_synth: directed programs against a word-addressed DRAM model.
// Each bus access (fetch, load, store) is compared with a hand-computed table
// of {kind, address, write data, cycles since previous access, V}.

module tb_cvp14_synth;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic [15:0] DataIn;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic        V;

    int n_chk = 0;
    int n_err = 0;

    always #5 Clk1 = ~Clk1;

    cvp14_synth #(.RESET_PC(16'h0000)) dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .DataIn  (DataIn),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataOut (DataOut),
        .V       (V)
    );

`ifdef CVP14_SAT_ADD_EN
    localparam logic [15:0] P1_R2  = 16'h7FFF;
    localparam logic [15:0] P1_AND = 16'h7F7F;
    localparam logic [15:0] P2_R2  = 16'h8000;
`else
    localparam logic [15:0] P1_R2  = 16'hFEFE;
    localparam logic [15:0] P1_AND = 16'h7E7E;
    localparam logic [15:0] P2_R2  = 16'h0100;
`endif

    // DRAM model: 256 words, address aliased on the low byte; a load port
    // lets the bench place programs while the core is held in reset.
    logic [15:0] mem [256];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_dat;

    always @(posedge Clk1) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (WR) mem[Addr[7:0]] <= DataOut;
        if (RD) DataIn <= mem[Addr[7:0]];
    end

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dat;
        logic [7:0]  gap;
        logic        v;
    } acc_t;

    acc_t exp_q[$];

    task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_dat  = d;
        @(negedge Clk1);
        ld_en   = 1'b0;
    endtask

    task automatic ex(input logic wr, input logic [15:0] a, input logic [15:0] d,
                      input logic [7:0] g, input logic v);
        acc_t e;
        e.wr = wr; e.addr = a; e.dat = d; e.gap = g; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic chk_rst_outputs(input string name);
        chk_eq({name, ".rd"},   16'(RD),   16'h0000);
        chk_eq({name, ".wr"},   16'(WR),   16'h0000);
        chk_eq({name, ".v"},    16'(V),    16'h0000);
        chk_eq({name, ".addr"}, Addr,      16'h0000);
        chk_eq({name, ".dout"}, DataOut,   16'h0000);
    endtask

    // Walk the expected-access queue; each entry waits (bounded) for the
    // next cycle with RD or WR high and compares everything about it.
    task automatic run_exp(input string name);
        acc_t e;
        int   idx = 0;
        int   gap;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            gap = 0;
            do begin
                @(negedge Clk1);
                gap++;
            end while (!(RD || WR) && gap < 20);
            chk_eq($sformatf("%s[%0d].gap",  name, idx), 16'(gap), 16'(e.gap));
            chk_eq($sformatf("%s[%0d].kind", name, idx), 16'({RD, WR}), e.wr ? 16'h0001 : 16'h0002);
            chk_eq($sformatf("%s[%0d].addr", name, idx), Addr, e.addr);
            chk_eq($sformatf("%s[%0d].dout", name, idx), DataOut, e.wr ? e.dat : 16'h0000);
            chk_eq($sformatf("%s[%0d].v",    name, idx), 16'(V), 16'(e.v));
            idx++;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        ld_en   = 1'b0;
        ld_addr = 8'h00;
        ld_dat  = 16'h0000;

        // ---------------- program 1: LLB/LHB/ADD ovf, ST/LD, BOV taken, AND, J, HALT
        @(negedge Clk1);
        ld(8'h00, 16'h227F);  // LLB r1,7F
        ld(8'h01, 16'h327F);  // LHB r1,7F     -> r1=7F7F
        ld(8'h02, 16'h0448);  // ADD r2,r1,r1  -> FEFE, V=1
        ld(8'h03, 16'h5414);  // ST r2,[r0+20]
        ld(8'h04, 16'h4614);  // LD r3,[r0+20]
        ld(8'h05, 16'h5615);  // ST r3,[r0+21]
        ld(8'h06, 16'h7002);  // BOV +2        -> 9
        ld(8'h07, 16'hF000);
        ld(8'h08, 16'hF000);
        ld(8'h09, 16'h563F);  // ST r3,[r0-1]  -> FFFF
        ld(8'h0A, 16'h1A58);  // AND r5,r1,r3
        ld(8'h0B, 16'h5A16);  // ST r5,[r0+22]
        ld(8'h0C, 16'h6001);  // J +1          -> E
        ld(8'h0D, 16'hF000);
        ld(8'h0E, 16'hF000);  // HALT, PC frozen at F
        chk_rst_outputs("p1_rst");
        Reset = 1'b0;

        ex(0, 16'h0000, 0, 1, 0);
        ex(0, 16'h0001, 0, 3, 0);
        ex(0, 16'h0002, 0, 3, 0);
        ex(0, 16'h0003, 0, 3, 1);
        ex(1, 16'h0014, P1_R2, 2, 1);
        ex(0, 16'h0004, 0, 1, 1);
        ex(0, 16'h0014, 0, 2, 1);
        ex(0, 16'h0005, 0, 2, 1);
        ex(1, 16'h0015, P1_R2, 2, 1);
        ex(0, 16'h0006, 0, 1, 1);
        ex(0, 16'h0009, 0, 3, 1);
        ex(1, 16'hFFFF, P1_R2, 2, 1);
        ex(0, 16'h000A, 0, 1, 1);
        ex(0, 16'h000B, 0, 3, 1);
        ex(1, 16'h0016, P1_AND, 2, 1);
        ex(0, 16'h000C, 0, 1, 1);
        ex(0, 16'h000E, 0, 3, 1);
        run_exp("p1");

        // Let HALT's DECODE/EXEC pass, then the bus must stay idle at PC=000F.
        repeat (2) @(negedge Clk1);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk1);
            chk_eq($sformatf("halt[%0d].rdwr", i), 16'({RD, WR}), 16'h0000);
            chk_eq($sformatf("halt[%0d].addr", i), Addr, 16'h000F);
        end

        // ---------------- program 2: ADD ovf then clear, BOV not taken, r0 write, reset mid-LD
        Reset = 1'b1;
        @(negedge Clk1);
        ld(8'h00, 16'h2280);  // LLB r1,80     -> FF80
        ld(8'h01, 16'h3280);  // LHB r1,80     -> 8080
        ld(8'h02, 16'h0448);  // ADD r2,r1,r1  -> 0100, V=1
        ld(8'h03, 16'h0200);  // ADD r1,r0,r0  -> 0, V=0
        ld(8'h04, 16'h7002);  // BOV +2 not taken -> 5
        ld(8'h05, 16'h5414);  // ST r2,[r0+20]
        ld(8'h06, 16'h2001);  // LLB r0,1 (ignored)
        ld(8'h07, 16'h5015);  // ST r0,[r0+21]
        ld(8'h08, 16'h4614);  // LD r3,[r0+20]
        chk_rst_outputs("p2_rst");
        Reset = 1'b0;

        ex(0, 16'h0000, 0, 1, 0);
        ex(0, 16'h0001, 0, 3, 0);
        ex(0, 16'h0002, 0, 3, 0);
        ex(0, 16'h0003, 0, 3, 1);
        ex(0, 16'h0004, 0, 3, 0);
        ex(0, 16'h0005, 0, 3, 0);
        ex(1, 16'h0014, P2_R2, 2, 0);
        ex(0, 16'h0006, 0, 1, 0);
        ex(0, 16'h0007, 0, 3, 0);
        ex(1, 16'h0015, 16'h0000, 2, 0);
        ex(0, 16'h0008, 0, 1, 0);
        ex(0, 16'h0014, 0, 2, 0);
        run_exp("p2");

        // Now in LD's EXEC; next cycle is MEMRD. Reset there drops the load.
        @(negedge Clk1);
        Reset = 1'b1;
        ld(8'h00, 16'h5616);  // ST r3,[r0+22] exposes r3 after restart
        chk_rst_outputs("mid_ld_rst");
        Reset = 1'b0;

        ex(0, 16'h0000, 0, 1, 0);
        ex(1, 16'h0016, 16'h0000, 2, 0);
        run_exp("p3");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
